// File: rtl/xbar_ovec_serializer_pkg.sv
// Shared constants and types for the xbar output-vector serializer slice.
package xbar_ovec_serializer_pkg;

    // Mirrors the tile-wide element width and xbar column count.
    localparam int unsigned QW = 32;
    localparam int unsigned XW = 16;

    typedef logic [QW-1:0] elem_t;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_ovec_serializer_if.sv
// Vector-in / scalar-out bus between xbar, the serializer and the output writer.
interface xbar_ovec_serializer_if #(
    parameter int unsigned QW       = xbar_ovec_serializer_pkg::QW,
    parameter int unsigned XW       = xbar_ovec_serializer_pkg::XW,
    parameter int unsigned OFSIZE_X = 4,
    parameter int unsigned OFSIZE_Y = 4
);
    import xbar_ovec_serializer_pkg::*;

    localparam int unsigned CW  = idx_w(XW);
    localparam int unsigned XPW = idx_w(OFSIZE_X);
    localparam int unsigned YPW = idx_w(OFSIZE_Y);

    // Vector side (from xbar)
    logic [QW-1:0]  vector_i [XW];
    logic           valid_i;
    logic           ready_o;

    // Scalar side (to packetiser / writer)
    logic [QW-1:0]  data_o;
    logic [CW-1:0]  chan_o;
    logic [XPW-1:0] ox_o;
    logic [YPW-1:0] oy_o;
    logic           last_pix_o;
    logic           last_frame_o;
    logic           valid_o;
    logic           ready_i;

    modport slave (
        input  vector_i, valid_i, ready_i,
        output ready_o, data_o, chan_o, ox_o, oy_o, last_pix_o, last_frame_o, valid_o
    );

    modport master (
        output vector_i, valid_i, ready_i,
        input  ready_o, data_o, chan_o, ox_o, oy_o, last_pix_o, last_frame_o, valid_o
    );

endinterface

// File: rtl/xbar_ovec_serializer_ovec_fifo.sv
// Whole-vector FIFO: one push writes all lanes, head vector is exposed for lane muxing.
module xbar_ovec_serializer_ovec_fifo #(
    parameter int unsigned QW    = 32,
    parameter int unsigned XW    = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk3,
    input  logic          rstn1,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [QW-1:0] wdata_i [XW],
    output logic          full_o,
    output logic          empty_o,
    output logic [QW-1:0] head_o [XW]
);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic [QW-1:0]   mem_q [DEPTH][XW];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    // Pointer and occupancy next state; push and pop are pre-qualified by the caller.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk3 or negedge rstn1) begin
        if (!rstn1) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: element contents need no reset.
    always_ff @(posedge clk3) begin
        if (push_i) begin
            for (int i = 0; i < int'(XW); i++) begin
                mem_q[wr_ptr_q][i] <= wdata_i[i];
            end
        end
    end

    // Head vector and status flags.
    always_comb begin
        for (int i = 0; i < int'(XW); i++) begin
            head_o[i] = mem_q[rd_ptr_q][i];
        end
        full_o  = (count_q == CNTW'(DEPTH));
        empty_o = (count_q == '0);
    end

endmodule

// File: rtl/xbar_ovec_serializer.sv
// Buffers xbar output vectors and re-emits them one lane per beat with pixel tags.
module xbar_ovec_serializer #(
    parameter int unsigned QW       = xbar_ovec_serializer_pkg::QW,
    parameter int unsigned XW       = xbar_ovec_serializer_pkg::XW,
    parameter int unsigned OFSIZE_X = 4,
    parameter int unsigned OFSIZE_Y = 4,
    parameter int unsigned DEPTH    = 2
) (
    input logic                   clk3,
    input logic                   rstn1,
    xbar_ovec_serializer_if.slave bus_io
);
    import xbar_ovec_serializer_pkg::*;

    localparam int unsigned CW  = idx_w(XW);
    localparam int unsigned XPW = idx_w(OFSIZE_X);
    localparam int unsigned YPW = idx_w(OFSIZE_Y);

    logic           full, empty;
    logic           push, pop, beat;
    logic           lane_last, ox_last, oy_last;
    logic [QW-1:0]  wdata [XW];
    logic [QW-1:0]  head  [XW];

    logic [CW-1:0]  lane_q, lane_d;
    logic [XPW-1:0] ox_q, ox_d;
    logic [YPW-1:0] oy_q, oy_d;

    // Handshake qualification; no pass-through when full, so ready depends only on state.
    always_comb begin
        for (int i = 0; i < int'(XW); i++) begin
            wdata[i] = bus_io.vector_i[i];
        end
        lane_last = (lane_q == CW'(XW - 1));
        ox_last   = (ox_q == XPW'(OFSIZE_X - 1));
        oy_last   = (oy_q == YPW'(OFSIZE_Y - 1));
        push      = bus_io.valid_i & ~full;
        beat      = ~empty & bus_io.ready_i;
        pop       = beat & lane_last;
    end

    xbar_ovec_serializer_ovec_fifo #(
        .QW    (QW),
        .XW    (XW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk3    (clk3),
        .rstn1   (rstn1),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    // Lane and pixel position advance; all held while empty or stalled.
    always_comb begin
        lane_d = lane_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        if (beat) begin
            if (lane_last) begin
                lane_d = '0;
                if (ox_last) begin
                    ox_d = '0;
                    oy_d = oy_last ? '0 : oy_q + 1'b1;
                end else begin
                    ox_d = ox_q + 1'b1;
                end
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk3 or negedge rstn1) begin
        if (!rstn1) begin
            lane_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
        end else begin
            lane_q <= lane_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
        end
    end

    // Outputs come straight from registered state, so they hold during stalls.
    always_comb begin
        bus_io.ready_o      = ~full;
        bus_io.valid_o      = ~empty;
        bus_io.data_o       = head[lane_q];
        bus_io.chan_o       = lane_q;
        bus_io.ox_o         = ox_q;
        bus_io.oy_o         = oy_q;
        bus_io.last_pix_o   = lane_last;
        bus_io.last_frame_o = lane_last & ox_last & oy_last;
    end

endmodule

// File: tb/tb_xbar_ovec_serializer.sv
// Self-checking bench for xbar_ovec_serializer (XW=4, 2x2 frame, DEPTH=2).
module tb_xbar_ovec_serializer;
    import xbar_ovec_serializer_pkg::*;

    localparam int unsigned TQW = 32;
    localparam int unsigned TXW = 4;
    localparam int unsigned TOX = 2;
    localparam int unsigned TOY = 2;
    localparam int unsigned TDP = 2;

    logic clk3  = 1'b0;
    logic rstn1 = 1'b0;
    always #5 clk3 = ~clk3;

    xbar_ovec_serializer_if #(.QW(TQW), .XW(TXW), .OFSIZE_X(TOX), .OFSIZE_Y(TOY)) bus ();

    xbar_ovec_serializer #(
        .QW       (TQW),
        .XW       (TXW),
        .OFSIZE_X (TOX),
        .OFSIZE_Y (TOY),
        .DEPTH    (TDP)
    ) dut (
        .clk3   (clk3),
        .rstn1  (rstn1),
        .bus_io (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  chan;
        logic        ox;
        logic        oy;
        logic        lp;
        logic        lf;
    } beat_t;

    typedef struct packed {
        logic [3:0][31:0] lanes;
        logic             ox;
        logic             oy;
    } vec_rec_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    pix_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic model_ox();
        return 1'(pix_cnt % TOX);
    endfunction

    function automatic logic model_oy();
        return 1'((pix_cnt / TOX) % TOY);
    endfunction

    // Queue the four beats an accepted vector must produce.
    task automatic expect_vec(input logic [3:0][31:0] lanes, input logic ox, input logic oy);
        beat_t b;
        for (int c = 0; c < 4; c++) begin
            b.data = lanes[c];
            b.chan = 2'(c);
            b.ox   = ox;
            b.oy   = oy;
            b.lp   = (c == 3);
            b.lf   = (c == 3) && ox && oy;
            sb_q.push_back(b);
        end
        pix_cnt++;
    endtask

    // Offer one vector; called just after a rising edge, returns just after the accepting edge.
    task automatic send(input logic [3:0][31:0] lanes, input logic ox, input logic oy);
        int waited = 0;
        for (int i = 0; i < 4; i++) bus.vector_i[i] = lanes[i];
        bus.valid_i = 1'b1;
        @(negedge clk3);
        while (!bus.ready_o && waited < 200) begin
            @(negedge clk3);
            waited++;
        end
        check("send_ready", 64'(bus.ready_o), 64'd1);
        if (bus.ready_o) expect_vec(lanes, ox, oy);
        @(posedge clk3);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic send_model(input logic [3:0][31:0] lanes);
        send(lanes, model_ox(), model_oy());
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk3);
            n++;
        end
        @(negedge clk3);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("idle_valid", 64'(bus.valid_o), 64'd0);
        @(posedge clk3);
        #1;
    endtask

    task automatic apply_reset();
        rstn1 = 1'b0;
        sb_q.delete();
        pix_cnt = 0;
        repeat (2) @(negedge clk3);
        rstn1 = 1'b1;
        @(posedge clk3);
        #1;
    endtask

    function automatic logic [3:0][31:0] rand_vec();
        logic [3:0][31:0] v;
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        return v;
    endfunction

    // Scoreboard compare on accepted beats plus hold-during-stall check.
    beat_t prev_q;
    logic  prev_stall_q = 1'b0;
    always @(negedge clk3) begin
        beat_t cur;
        beat_t exp;
        if (!rstn1) begin
            prev_stall_q <= 1'b0;
        end else begin
            cur = {bus.data_o, bus.chan_o, bus.ox_o, bus.oy_o, bus.last_pix_o, bus.last_frame_o};
            if (prev_stall_q) check("stall_hold", 64'({bus.valid_o, cur}), 64'({1'b1, prev_q}));
            if (bus.valid_o && bus.ready_i) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("beat", 64'(cur), 64'(exp));
                end
            end
            prev_stall_q <= bus.valid_o & ~bus.ready_i;
            prev_q       <= cur;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    vec_rec_t tbl [5];
    logic [3:0][31:0] v;

    initial begin
        tbl[0] = '{lanes: {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, ox: 1'b0, oy: 1'b0};
        tbl[1] = '{lanes: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001}, ox: 1'b1, oy: 1'b0};
        tbl[2] = '{lanes: {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h80000000}, ox: 1'b0, oy: 1'b1};
        tbl[3] = '{lanes: {32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A}, ox: 1'b1, oy: 1'b1};
        tbl[4] = '{lanes: {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A}, ox: 1'b0, oy: 1'b0};

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) bus.vector_i[i] = '0;

        // Reset then idle
        #2;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk3);
            check("idle_out", 64'({bus.valid_o, bus.ready_o, bus.chan_o, bus.ox_o, bus.oy_o}),
                  64'({1'b0, 1'b1, 2'd0, 1'b0, 1'b0}));
        end
        @(posedge clk3);
        #1;

        // Single vector: first lane the cycle after push, four consecutive beats
        send(tbl[0].lanes, tbl[0].ox, tbl[0].oy);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk3);
            check("consec_valid", 64'({bus.valid_o, bus.chan_o}), 64'({1'b1, 2'(k)}));
        end
        drain();

        // Full frame plus wrap back to (0,0)
        apply_reset();
        for (int i = 0; i < 5; i++) send(tbl[i].lanes, tbl[i].ox, tbl[i].oy);
        drain();

        // Backpressure: two vectors fill the FIFO, third waits until the first pops
        apply_reset();
        bus.ready_i = 1'b0;
        send_model(tbl[1].lanes);
        send_model(tbl[2].lanes);
        for (int i = 0; i < 4; i++) bus.vector_i[i] = tbl[3].lanes[i];
        bus.valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk3);
            check("full_ready", 64'(bus.ready_o), 64'd0);
        end
        @(posedge clk3);
        #1;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk3);
            check("ready_rise", 64'(bus.ready_o), 64'(k == 4));
        end
        if (bus.ready_o) expect_vec(tbl[3].lanes, model_ox(), model_oy());
        @(posedge clk3);
        #1;
        bus.valid_i = 1'b0;
        drain();

        // Toggling ready with random vector arrivals
        apply_reset();
        fork
            begin
                repeat (120) begin
                    @(posedge clk3);
                    #1;
                    bus.ready_i = ~bus.ready_i;
                end
            end
            begin
                for (int n = 0; n < 6; n++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk3);
                        #1;
                    end
                    v = rand_vec();
                    send_model(v);
                end
            end
        join
        bus.ready_i = 1'b1;
        drain();

        // Reset in the middle of pixel (1,0)
        apply_reset();
        send_model(rand_vec());
        send_model(rand_vec());
        begin
            int n = 0;
            @(negedge clk3);
            while (!(bus.valid_o && bus.ready_i && bus.ox_o == 1'b1 && bus.chan_o == 2'd1)
                   && n < 100) begin
                @(negedge clk3);
                n++;
            end
            check("mid_pixel_seen", 64'({bus.ox_o, bus.chan_o}), 64'({1'b1, 2'd1}));
        end
        @(posedge clk3);
        #1;
        rstn1 = 1'b0;
        sb_q.delete();
        pix_cnt = 0;
        #1;
        check("async_rst_out", 64'({bus.valid_o, bus.ready_o, bus.chan_o, bus.ox_o, bus.oy_o}),
              64'({1'b0, 1'b1, 2'd0, 1'b0, 1'b0}));
        repeat (2) @(negedge clk3);
        rstn1 = 1'b1;
        @(posedge clk3);
        #1;
        send_model(tbl[4].lanes);
        @(negedge clk3);
        check("post_rst_first", 64'({bus.valid_o, bus.chan_o, bus.ox_o, bus.oy_o}),
              64'({1'b1, 2'd0, 1'b0, 1'b0}));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xbar_ovec_serializer.md
Name: xbar_ovec_serializer

Overview:
Sits directly downstream of xbar in the conv tile and consumes its XW-lane output vectors, one per output pixel, through a valid/ready handshake. Each vector is buffered in a small FIFO and re-emitted as a scalar stream, one lane (output channel) per beat. Every beat is tagged with its channel index and output-pixel coordinates, plus pixel-last and frame-last flags. The scalar stream feeds the NoC packetiser / output writer on the same clock.

Parameters:
QW, 32, bit width of one element (float32 bit pattern, opaque to this block)
XW, 16, lanes per input vector (xbar column count)
OFSIZE_X, 4, output feature map width in pixels
OFSIZE_Y, 4, output feature map height in pixels
DEPTH, 2, vector FIFO depth in entries; power of two, at least 2

Ports:
clk3  in  1  clock; all state on rising edge
rstn1  in  1  asynchronous active-low reset
vector_i  in  XW x QW  unpacked array of lanes from xbar (vector_o)
valid_i  in  1  vector_i valid (xbar valid_o)
ready_o  out  1  FIFO can accept a vector (to xbar ready_i)
data_o  out  QW  current scalar element
chan_o  out  clog2(XW)  lane/channel index of data_o
ox_o  out  clog2(OFSIZE_X)  output pixel x of data_o
oy_o  out  clog2(OFSIZE_Y)  output pixel y of data_o
last_pix_o  out  1  high when chan_o == XW-1
last_frame_o  out  1  high on the final element of the frame: last_pix_o and ox_o == OFSIZE_X-1 and oy_o == OFSIZE_Y-1
valid_o  out  1  data_o and tags valid
ready_i  in  1  downstream accepts

Behaviour:
- Reset (async assert, synchronous-style deassert on clk3):
  - FIFO count = 0, write pointer = 0, read pointer = 0, lane counter = 0, ox = 0, oy = 0.
  - Outputs during/after reset: valid_o = 0, ready_o = 1, data_o = don't care, chan_o/ox_o/oy_o = 0.
  - Reset mid-frame discards all buffered vectors and position state; the next accepted vector is pixel (0,0).
- Input side:
  - ready_o = (count != DEPTH), combinational from registered count; no same-cycle pass-through when full.
  - Push on valid_i & ready_o: all XW lanes written into mem[wr_ptr] in one cycle; wr_ptr increments with wrap at DEPTH.
- Output side:
  - valid_o = (count != 0).
  - data_o = mem[rd_ptr][lane]; chan_o = lane; ox_o = ox; oy_o = oy. All outputs derive from registers and are stable while valid_o & ~ready_i.
  - Beat on valid_o & ready_i: lane increments.
  - At lane == XW-1 the beat pops: lane returns to 0, rd_ptr increments (wrap at DEPTH), and ox increments.
  - ox wraps at OFSIZE_X-1 to 0 and increments oy; oy wraps at OFSIZE_Y-1 to 0, i.e. the frame restarts at (0,0) with no idle cycle.
- Latency: a vector pushed into an empty FIFO at cycle t presents lane 0 at cycle t+1. Sustained throughput is 1 element per cycle; the input sustains 1 vector per XW cycles.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. This is legal when count is 1..DEPTH-1; when count == DEPTH only the pop occurs and ready_o rises the next cycle.
- Empty: valid_o = 0; lane, ox and oy are held.
- Lanes are emitted in ascending order, 0 to XW-1. Element bits are passed unmodified.

Decomposition:
- Shared package (tile_pkg): QW and XW constants (mirroring `QW/`XW) and an element typedef logic [QW-1:0].
- One sub-module: ovec_fifo (DEPTH x XW x QW storage plus pointers and count, exposing full/empty and the head vector).
- Lane and pixel counters stay in the top module.

Test Plan:
- Reset then idle, XW=4, OFSIZE 2x2 -> valid_o = 0, ready_o = 1, tags 0 for 10 cycles.
- One vector {0x3F800000, 0x40000000, 0x40400000, 0x40800000}, ready_i = 1 -> 4 beats on consecutive cycles, first at t+1, in that order, chan 0..3, last_pix_o on beat 4, ox = oy = 0.
- 4 back-to-back vectors (full frame), ready_i = 1 -> 16 beats with tags (0,0) (1,0) (0,1) (1,1); last_frame_o only on beat 16; the 5th vector restarts at (0,0).
- ready_i = 0 while 3 vectors are offered -> 2 accepted, ready_o = 0 thereafter. Raise ready_i -> ready_o returns 1 in the cycle after the 4th beat's pop, and no element is lost or duplicated.
- ready_i toggling 1010..., valid_i random -> data and tags held stable during stalls; scoreboard matches lane order.
- Assert rstn1 after beat 2 of pixel (1,0) -> valid_o = 0 immediately; after release, the next vector emits at (0,0), chan 0.
